// File: rtl/bird_sprite_draw_if.sv
// Video stream and bitmap ROM signals for the bird sprite overlay stage.
// slave is the overlay stage's view of the signals; master is the view of whatever drives it.
interface bird_sprite_draw_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        blank;
    logic [11:0] rgb_in;
    logic [10:0] bird_x;
    logic [10:0] bird_y;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        blank_out;
    logic [11:0] rgb_out;
    logic        bird_on;

    modport master (
        output hcount, vcount, blank, rgb_in, bird_x, bird_y, rom_data,
        input  rom_addr, hcount_out, vcount_out, blank_out, rgb_out, bird_on
    );

    modport slave (
        input  hcount, vcount, blank, rgb_in, bird_x, bird_y, rom_data,
        output rom_addr, hcount_out, vcount_out, blank_out, rgb_out, bird_on
    );
endinterface

// File: rtl/bird_sprite_draw.sv
// Bird sprite overlay: fetches one 16-bit bitmap row per scanline during hblank
// and composites BIRD_COLOR over the background stream with 1-cycle latency.
//
// state     | meaning
// S_IDLE    | waiting for hcount == H_ACTIVE to start the row fetch
// S_ADDR    | rom_addr registered, ROM output settling
// S_CAPTURE | rom_data captured into the row buffer
module bird_sprite_draw #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_TOTAL    = 525,
    parameter logic [11:0] BIRD_COLOR = 12'hFF0
) (
    input logic               clk,
    input logic               rst,
    bird_sprite_draw_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [10:0] LP_H_FETCH = 11'(H_ACTIVE);
    localparam logic [10:0] LP_V_LAST  = 11'(V_TOTAL - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [10:0] r_x_lat;
    logic [10:0] r_y_lat;
    logic [15:0] r_row_buf;
    logic        r_row_valid;
    logic [3:0]  r_rom_addr;
    logic [11:0] r_rgb_out;
    logic        r_bird_on;
    logic [10:0] r_hcount_out;
    logic [10:0] r_vcount_out;
    logic        r_blank_out;

    logic        w_hstart;
    logic        w_frame_end;
    logic [10:0] w_next_line;
    logic [10:0] w_y_eff;
    logic [3:0]  w_line_off;
    logic        w_in_range;
    logic        w_latch;
    logic        w_fetch;
    logic        w_miss;
    logic        w_capture;

    assign w_hstart    = (bus.hcount == LP_H_FETCH);
    assign w_frame_end = (bus.vcount == LP_V_LAST);
    assign w_next_line = w_frame_end ? 11'd0 : bus.vcount + 11'd1;
    // On the frame-end line the new position is used straight from the input.
    assign w_y_eff     = w_frame_end ? bus.bird_y : r_y_lat;
    assign w_line_off  = w_next_line[3:0] - w_y_eff[3:0];
    assign w_in_range  = ({1'b0, w_next_line} >= {1'b0, w_y_eff}) &&
                         ({1'b0, w_next_line} <  ({1'b0, w_y_eff} + 12'd16));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_fetch      = 1'b0;
        w_miss       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hstart) begin
                    w_latch = w_frame_end;
                    if (w_in_range) begin
                        w_fetch      = 1'b1;
                        w_state_next = S_ADDR;
                    end else begin
                        w_miss = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_lat     <= 11'd0;
            r_y_lat     <= 11'd0;
            r_rom_addr  <= 4'd0;
            r_row_buf   <= 16'd0;
            r_row_valid <= 1'b0;
        end else begin
            if (w_latch) begin
                r_x_lat <= bus.bird_x;
                r_y_lat <= bus.bird_y;
            end
            if (w_fetch) begin
                r_rom_addr <= w_line_off;
            end
            if (w_miss) begin
                r_row_valid <= 1'b0;
            end
            if (w_capture) begin
                r_row_buf   <= bus.rom_data;
                r_row_valid <= 1'b1;
            end
        end
    end

    logic [11:0] w_hc12;
    logic [3:0]  w_dx;
    logic [3:0]  w_bit_idx;
    logic        w_in_sprite;
    logic        w_bird_on_next;

    // 12-bit compare keeps x_lat+16 from wrapping for positions near 2047.
    assign w_hc12         = {1'b0, bus.hcount};
    assign w_dx           = bus.hcount[3:0] - r_x_lat[3:0];
    assign w_bit_idx      = 4'd15 - w_dx;
    assign w_in_sprite    = r_row_valid && !bus.blank &&
                            (w_hc12 >= {1'b0, r_x_lat}) &&
                            (w_hc12 <  ({1'b0, r_x_lat} + 12'd16));
    assign w_bird_on_next = w_in_sprite && r_row_buf[w_bit_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb_out    <= 12'd0;
            r_bird_on    <= 1'b0;
            r_hcount_out <= 11'd0;
            r_vcount_out <= 11'd0;
            r_blank_out  <= 1'b1;
        end else begin
            r_rgb_out    <= w_bird_on_next ? BIRD_COLOR : bus.rgb_in;
            r_bird_on    <= w_bird_on_next;
            r_hcount_out <= bus.hcount;
            r_vcount_out <= bus.vcount;
            r_blank_out  <= bus.blank;
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.rgb_out    = r_rgb_out;
    assign bus.bird_on    = r_bird_on;
    assign bus.hcount_out = r_hcount_out;
    assign bus.vcount_out = r_vcount_out;
    assign bus.blank_out  = r_blank_out;
endmodule

// File: tb/tb_bird_sprite_draw.sv
// Bench for bird_sprite_draw: sparse scanline stimulus with random background
// and bird positions, checked every cycle against a line-level sprite model.
module tb_bird_sprite_draw;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;
    localparam logic [11:0] BC = 12'hFF0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bird_sprite_draw_if bus ();
    logic [15:0] rom [16];
    assign bus.rom_data = rom[bus.rom_addr];

    bird_sprite_draw #(.H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .BIRD_COLOR(BC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // model state: frame position, buffered row, fetch in flight
    int          m_xl = 0, m_yl = 0, m_pend = 0;
    bit          m_rv = 0;
    logic [15:0] m_row = 0, m_pend_row = 0;
    logic [11:0] e_rgb;
    logic        e_on, e_b;
    logic [10:0] e_h, e_v;
    int          e_addr;

    int ln_cnt, ln_min, ln_max, ln_addr;
    int win_on = 0;
    int on_blank = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int h, v, dx, nl;
        e_addr = -1;
        if (rst) begin
            m_xl = 0; m_yl = 0; m_rv = 0; m_row = 0; m_pend = 0;
            e_on = 0; e_rgb = 0; e_h = 0; e_v = 0; e_b = 1;
        end else begin
            h  = int'(bus.hcount);
            v  = int'(bus.vcount);
            dx = h - m_xl;
            e_on  = m_rv && !bus.blank && dx >= 0 && dx < 16 && m_row[15 - dx];
            e_rgb = e_on ? BC : bus.rgb_in;
            e_h = bus.hcount; e_v = bus.vcount; e_b = bus.blank;
            if (h == H_ACTIVE) begin
                nl = (v == V_TOTAL - 1) ? 0 : v + 1;
                if (v == V_TOTAL - 1) begin
                    m_xl = int'(bus.bird_x);
                    m_yl = int'(bus.bird_y);
                end
                if (nl >= m_yl && nl < m_yl + 16) begin
                    m_pend = 2;
                    m_pend_row = rom[nl - m_yl];
                    e_addr = nl - m_yl;
                end else begin
                    m_rv = 0;
                end
            end else if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_row = m_pend_row;
                    m_rv  = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_edge();
        #1;
        check("rgb_out", 32'(bus.rgb_out), 32'(e_rgb));
        check("bird_on", 32'(bus.bird_on), 32'(e_on));
        check("hcount_out", 32'(bus.hcount_out), 32'(e_h));
        check("vcount_out", 32'(bus.vcount_out), 32'(e_v));
        check("blank_out", 32'(bus.blank_out), 32'(e_b));
        if (e_addr >= 0) check("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
        if (bus.bird_on === 1'b1) begin
            ln_cnt++;
            win_on++;
            if (int'(bus.hcount_out) < ln_min) ln_min = int'(bus.hcount_out);
            if (int'(bus.hcount_out) > ln_max) ln_max = int'(bus.hcount_out);
            if (bus.blank_out !== 1'b0) on_blank++;
        end
        if (int'(bus.hcount_out) == H_ACTIVE) ln_addr = int'(bus.rom_addr);
    end

    task automatic cyc(input int h, input int v, input bit r);
        @(negedge clk);
        rst = r;
        bus.hcount = 11'(h);
        bus.vcount = 11'(v);
        bus.blank  = (h >= H_ACTIVE) || (v >= V_ACTIVE);
        bus.rgb_in = 12'($urandom);
        if (r) begin
            #1;
            check("rst_rgb_out", 32'(bus.rgb_out), 32'd0);
            check("rst_bird_on", 32'(bus.bird_on), 32'd0);
            check("rst_hcount_out", 32'(bus.hcount_out), 32'd0);
            check("rst_vcount_out", 32'(bus.vcount_out), 32'd0);
            check("rst_blank_out", 32'(bus.blank_out), 32'd1);
            check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        end
    endtask

    task automatic line(input int v, input int rst_h);
        int lo, hi;
        ln_cnt = 0; ln_min = 4096; ln_max = -1; ln_addr = -1;
        for (int h = 0; h < 3; h++) cyc(h, v, 1'b0);
        lo = m_xl - 4;  if (lo < 3) lo = 3;
        hi = m_xl + 20; if (hi > 624) hi = 624;
        for (int h = lo; h <= hi; h++) cyc(h, v, 1'b0);
        for (int h = 625; h <= 645; h++) cyc(h, v, h == rst_h);
    endtask

    task automatic lines(input int a, input int b);
        for (int v = a; v <= b; v++) line(v, -1);
    endtask

    initial begin
        int lo, hi, ex, ey;
        bus.hcount = 0; bus.vcount = 100; bus.blank = 0; bus.rgb_in = 0;
        bus.bird_x = 11'd100; bus.bird_y = 11'd50;
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h8001; rom[15] = 16'hFFFF;

        // reset held, released on line 100: no bird until first latch
        for (int h = 0; h < 5; h++) cyc(h, 100, 1'b1);
        win_on = 0;
        lines(100, 105); lines(479, 481); lines(520, 524);
        check("no_bird_after_reset", win_on, 0);

        // frame with bird (100,50)
        lines(0, 3);
        for (int v = 45; v <= 70; v++) begin
            line(v, -1);
            if (v == 49) check("l49_rom_addr", ln_addr, 0);
            if (v == 50) begin
                check("l50_count", ln_cnt, 2);
                check("l50_first", ln_min, 100);
                check("l50_last", ln_max, 115);
            end
            if (v == 64) check("l64_rom_addr", ln_addr, 15);
            if (v == 65) begin
                check("l65_count", ln_cnt, 16);
                check("l65_rom_addr_held", ln_addr, 15);
            end
            if (v == 66) check("l66_count", ln_cnt, 0);
        end
        win_on = 0;
        lines(200, 205);
        check("old_frame_no_y200", win_on, 0);
        bus.bird_y = 11'd200;
        lines(300, 303); lines(479, 481); lines(520, 524);

        // next frame: bird moved to y=200
        win_on = 0;
        lines(45, 55);
        check("new_frame_no_y50", win_on, 0);
        for (int v = 199; v <= 216; v++) begin
            line(v, -1);
            if (v == 200) begin
                check("l200_count", ln_cnt, 2);
                check("l200_first", ln_min, 100);
            end
        end
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        bus.bird_x = 11'd630; bus.bird_y = 11'd50;
        lines(300, 301); lines(520, 524);

        // right-edge clipping, then reset pulsed during CAPTURE on line 60
        on_blank = 0;
        for (int v = 49; v <= 59; v++) begin
            line(v, -1);
            if (v == 50) begin
                check("edge_count", ln_cnt, 10);
                check("edge_first", ln_min, 630);
                check("edge_last", ln_max, 639);
            end
        end
        line(60, 642);
        win_on = 0;
        lines(61, 70); lines(479, 481); lines(520, 523);
        check("no_bird_after_midfetch_rst", win_on, 0);
        ex = $urandom_range(0, 600); ey = $urandom_range(1, 460);
        bus.bird_x = 11'(ex); bus.bird_y = 11'(ey);
        line(524, -1);
        for (int v = ey - 1; v <= ey + 16; v++) begin
            line(v, -1);
            if (v == ey) begin
                check("rand_pos_count", ln_cnt, 16);
                check("rand_pos_first", ln_min, ex);
                check("rand_pos_last", ln_max, ex + 15);
            end
        end
        bus.bird_x = 11'($urandom_range(0, 700)); bus.bird_y = 11'($urandom_range(0, 524));
        lines(520, 524);

        // random frames: random bitmap, position (incl. far-right x), mid-frame moves
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
            lines(0, 2);
            lo = m_yl - 1;  if (lo < 3) lo = 3;
            hi = m_yl + 17; if (hi > 519) hi = 519;
            if (lo <= hi) lines(lo, hi);
            bus.bird_x = 11'($urandom); bus.bird_y = 11'($urandom);
            lines(300, 302);
            if ($urandom_range(0, 3) == 0) bus.bird_x = 11'($urandom_range(2032, 2047));
            else bus.bird_x = 11'($urandom_range(0, 700));
            bus.bird_y = 11'($urandom_range(0, 524));
            lines(520, 524);
        end

        check("never_on_in_blank", on_blank, 0);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
